// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache and D-cache paths, one transaction at a time
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] i_grant_cnt,
  output logic [15:0] d_grant_cnt,
  output logic [15:0] conflict_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, nextState;
  logic pri, ownerD, latWr, grant, grantD, conflict, last;
  logic [3:0] waitCnt;
  always_comb begin
    conflict = i_req && d_req;
    grant = state == IDLE && (i_req || d_req);
    grantD = conflict ? !pri : d_req;
    last = state == WAIT && waitCnt == 4'd0;
    nextState = state == IDLE ? (grant ? ISSUE : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT ? (last ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pri <= 1'b0;
      ownerD <= 1'b0;
      latWr <= 1'b0;
      waitCnt <= 4'd0;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= 16'h0;
      mem_wdata <= 16'h0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_rdata <= 16'h0;
      d_rdata <= 16'h0;
      i_grant_cnt <= 16'h0;
      d_grant_cnt <= 16'h0;
      conflict_cnt <= 16'h0;
    end else begin
      state <= nextState;
      mem_en <= grant;
      mem_wr <= grant && grantD && d_wr;
      mem_addr <= grant ? (grantD ? d_addr : i_addr) : 16'h0;
      mem_wdata <= grant && grantD ? d_wdata : 16'h0;
      waitCnt <= state == ISSUE ? 4'(MEM_LAT - 1) : waitCnt - 4'd1;
      i_done <= last && !ownerD;
      d_done <= last && ownerD;
      if (last && !ownerD) i_rdata <= mem_rdata;
      if (last && ownerD && !latWr) d_rdata <= mem_rdata;
      if (grant) begin
        ownerD <= grantD;
        latWr <= grantD && d_wr;
        pri <= pri ^ conflict;
        i_grant_cnt <= i_grant_cnt + 16'(!grantD);
        d_grant_cnt <= d_grant_cnt + 16'(grantD);
        conflict_cnt <= conflict_cnt + 16'(conflict);
      end
    end
  end
endmodule
